// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side signal bundle of the data cache controller.
// The controller connects through the slave modport; pipeline and memory drive the master side.
interface dcache_ctrl_if;
    logic         core_req_i;
    logic         core_we_i;
    logic [31:0]  core_addr_i;
    logic [31:0]  core_data_i;
    logic [31:0]  core_data_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_data_i, mem_data_i, mem_ack_i,
        output core_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_data_i, mem_data_i, mem_ack_i,
        input  core_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller (32B lines, word access).
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics counters.
module dcache_ctrl #(
    parameter int NUM_LINES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [255:0]         data_arr [NUM_LINES];

    logic [IDX_W-1:0] req_idx, idx_q;
    logic [TAG_W-1:0] req_tag, tag_q;
    logic [2:0]       req_word;
    logic             hit;
    logic             hit_go, miss_go, store_we, refill_we;

    logic         stall;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data;
    logic         unused_addr_lsb;

    assign req_word = bus.core_addr_i[4:2];
    assign req_idx  = bus.core_addr_i[IDX_W+4:5];
    assign req_tag  = bus.core_addr_i[31:IDX_W+5];
    assign unused_addr_lsb = &{1'b0, bus.core_addr_i[1:0]};

    assign hit = bus.core_req_i & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);

    // Load data is always the addressed word; only meaningful on an unstalled request.
    assign bus.core_data_o = data_arr[req_idx][{req_word, 5'b0} +: 32];
    assign bus.stall_o     = stall;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_data_o  = mem_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Memory-side outputs come only from registered index/tag and an array
    // line that cannot change while a request is outstanding, so they hold until ack.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        hit_go    = 1'b0;
        miss_go   = 1'b0;
        store_we  = 1'b0;
        refill_we = 1'b0;
        case (state_q)
            IDLE: begin
                stall = bus.core_req_i & ~hit;
                if (hit) begin
                    hit_go   = 1'b1;
                    store_we = bus.core_we_i;
                end else if (bus.core_req_i) begin
                    miss_go = 1'b1;
                    state_d = (valid_q[req_idx] & dirty_q[req_idx]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {tag_arr[idx_q], idx_q, 5'b0};
                mem_data = data_arr[idx_q];
                if (bus.mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, 5'b0};
                if (bus.mem_ack_i) begin
                    refill_we = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else begin
            if (miss_go) begin
                idx_q <= req_idx;
                tag_q <= req_tag;
            end
            if (refill_we) begin
                valid_q[idx_q] <= 1'b1;
                dirty_q[idx_q] <= 1'b0;
            end
            if (store_we) dirty_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data storage is intentionally not reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            data_arr[idx_q] <= bus.mem_data_i;
            tag_arr[idx_q]  <= tag_q;
        end
        if (store_we) data_arr[req_idx][{req_word, 5'b0} +: 32] <= bus.core_data_i;
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_go)  hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (miss_go) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat-memory golden model plus cache-tag model,
// directed test-plan scenarios followed by randomized conflicting accesses.
module tb_dcache_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dcache_ctrl_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
`endif
    );

    typedef struct {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic        miss;
        logic        wb;
        logic [31:0] wb_addr;
        int          exp_stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: cache directory plus the latest value of every word ever written.
    logic        m_valid [16];
    logic        m_dirty [16];
    logic [22:0] m_tag   [16];
    logic [31:0]  gold [logic [31:0]];
    logic [255:0] bmem [logic [31:0]];

    int          fixed_delay = 2;
    logic        mon_en = 1'b1;
    int          stall_cnt = 0;
    logic        seen_wb = 1'b0, seen_rf = 1'b0;
    logic [31:0] seen_wb_addr = '0, seen_rf_addr = '0;
    logic        busy = 1'b0;
    int          wcnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [255:0] back_line(input logic [31:0] la);
        logic [255:0] l;
        if (bmem.exists(la)) return bmem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] gold_get(input logic [31:0] wa);
        logic [255:0] l;
        if (gold.exists(wa)) return gold[wa];
        l = back_line({wa[31:5], 5'b0});
        return l[{wa[4:2], 5'b0} +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_dirty[i])
                for (int w = 0; w < 8; w++)
                    gold.delete({m_tag[i], 4'(i), 3'(w), 2'b0});
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Issue one access starting just after a rising edge; returns just after the committing edge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [3:0]  idx;
        logic [22:0] tag;
        logic [31:0] wa;
        int          cyc;
        idx = addr[8:5];
        tag = addr[31:9];
        wa  = {addr[31:2], 2'b0};
        e.is_load = !we;
        e.addr    = addr;
        e.data    = gold_get(wa);
        e.miss    = !(m_valid[idx] && m_tag[idx] == tag);
        e.wb      = e.miss && m_valid[idx] && m_dirty[idx];
        e.wb_addr = {m_tag[idx], idx, 5'b0};
        if (fixed_delay < 0)  e.exp_stall = -1;
        else if (!e.miss)     e.exp_stall = 0;
        else                  e.exp_stall = 1 + (fixed_delay + 1) + (e.wb ? fixed_delay + 1 : 0);
        if (e.miss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_dirty[idx] = 1'b1;
            gold[wa]     = data;
        end
        sb_q.push_back(e);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_addr_i = addr;
        bus.core_data_i = data;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (!bus.stall_o) break;
            cyc++;
            if (cyc > 200) begin
                $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, required release", cyc);
                $fatal(1, "access hung");
            end
        end
        @(posedge clk_i);
        #1;
        bus.core_req_i = 1'b0;
    endtask

    // Memory model: acks after fixed_delay (or random 0..3) extra cycles of a request.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            bus.mem_ack_i = 1'b0;
            busy = 1'b0;
        end else begin
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                busy = 1'b0;
            end
            if (bus.mem_req_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    if (bus.mem_we_o) begin
                        seen_wb = 1'b1;
                        seen_wb_addr = bus.mem_addr_o;
                        for (int w = 0; w < 8; w++)
                            check32("wb_data", bus.mem_data_o[w*32 +: 32],
                                    gold_get(bus.mem_addr_o + 32'(4*w)));
                        bmem[bus.mem_addr_o] = bus.mem_data_o;
                    end else begin
                        seen_rf = 1'b1;
                        seen_rf_addr = bus.mem_addr_o;
                        bus.mem_data_i = back_line(bus.mem_addr_o);
                    end
                    bus.mem_ack_i = 1'b1;
                end else begin
                    wcnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: each unstalled request completes one scoreboard entry.
    always @(negedge clk_i) begin
        exp_t e;
        if (mon_en && rst_i && bus.core_req_i) begin
            if (bus.stall_o) begin
                stall_cnt++;
            end else if (sb_q.size() == 0) begin
                check32("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.is_load) check32("load_data", bus.core_data_o, e.data);
                check32("miss", 32'(stall_cnt > 0), 32'(e.miss));
                if (e.exp_stall >= 0) check32("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
                check32("wb_seen", 32'(seen_wb), 32'(e.wb));
                if (e.wb) check32("wb_addr", seen_wb_addr, e.wb_addr);
                check32("refill_seen", 32'(seen_rf), 32'(e.miss));
                if (e.miss) check32("refill_addr", seen_rf_addr, {e.addr[31:5], 5'b0});
                stall_cnt = 0;
                seen_wb = 1'b0;
                seen_rf = 1'b0;
            end
        end
    end

    initial begin
        logic [255:0] l;
        int           cyc;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_addr_i = 32'h104;
        bus.core_data_i = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_data_i  = '0;
        #2;
        check32("rst_stall_req", 32'(bus.stall_o), 32'd1);
        check32("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check32("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        check32("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check32("rst_mem_data", 32'(|bus.mem_data_o), 32'd0);
        bus.core_req_i = 1'b0;
        #1;
        check32("rst_stall_noreq", 32'(bus.stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        l = back_line(32'h100);
        l[63:32] = 32'hDEADBEEF;
        bmem[32'h100] = l;
        fixed_delay = 2;
        access(1'b0, 32'h0000_0104, '0);
        check32("cold_load_value", gold_get(32'h104), 32'hDEADBEEF);
        access(1'b1, 32'h0000_0108, 32'h12345678);
        access(1'b0, 32'h0000_0108, '0);
`ifdef DCACHE_STATS_EN
        check32("hit_cnt", hit_cnt, 32'd3);
        check32("miss_cnt", miss_cnt, 32'd1);
`endif
        access(1'b0, 32'h0000_0300, '0);
        access(1'b1, 32'h0000_0010, 32'hCAFEF00D);
        access(1'b0, 32'h0000_0010, '0);
        access(1'b0, 32'h0000_0210, '0);

        // Reset in the middle of a refill; the aborted fill must leave nothing behind.
        fixed_delay = 3;
        mon_en = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_addr_i = 32'h0000_0404;
        bus.core_req_i  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!(bus.mem_req_o && !bus.mem_we_o) && cyc < 50);
        check32("reach_refill", 32'(bus.mem_req_o && !bus.mem_we_o), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check32("midrst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check32("midrst_mem_addr", bus.mem_addr_o, 32'd0);
        check32("midrst_stall", 32'(bus.stall_o), 32'd1);
        bus.core_req_i = 1'b0;
        #1;
        check32("midrst_stall_noreq", 32'(bus.stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        stall_cnt = 0;
        seen_wb = 1'b0;
        seen_rf = 1'b0;
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        access(1'b0, 32'h0000_0404, '0);
        access(1'b0, 32'h0000_0210, '0);

        fixed_delay = -1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk_i);
                check32("idle_stall", 32'(bus.stall_o), 32'd0);
                @(posedge clk_i);
                #1;
            end
        end

        @(negedge clk_i);
        check32("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the off-chip data memory. It receives the MEM-stage load/store request (MemRead/MemWrite, ALU result as address, store data) and answers hits in the same cycle. On a miss it raises `stall_o`, which freezes the pipeline registers (including the EX/MEM register). It then writes back a dirty victim, refills the line over a req/ack memory handshake, and releases the stall.

## Interface
- `NUM_LINES`, 16: number of cache lines; must be a power of two, minimum 2; `IDX_W = log2(NUM_LINES)`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `core_req_i`  in  1  access request; equals MemRead | MemWrite of the MEM stage.
- `core_we_i`  in  1  1 = store, 0 = load.
- `core_addr_i`  in  32  byte address; bits [1:0] are ignored (word access only).
- `core_data_i`  in  32  store data.
- `core_data_o`  out  32  load data; valid whenever `core_req_i` is high and `stall_o` is low.
- `stall_o`  out  1  pipeline freeze.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = line write-back, 0 = line fetch.
- `mem_addr_o`  out  32  line-aligned address; bits [4:0] are always 0.
- `mem_data_o`  out  256  victim line data.
- `mem_data_i`  in  256  fetched line data.
- `mem_ack_i`  in  1  memory completion; sampled only while `mem_req_o` is high.

## Operation
- Address split:
  - byte offset [4:0]; word select [4:2]
  - index [IDX_W+4:5]
  - tag [31:IDX_W+5], `TAG_W = 27 - IDX_W` bits
- Per line state: valid bit, dirty bit, tag, 256-bit data. Word w occupies data bits [32w+31:32w].
- Hit = `core_req_i` & valid[index] & (tag[index] == address tag).
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - `stall_o = core_req_i & ~hit` (combinational).
  - Load hit: `core_data_o` = the selected word.
  - Store hit: the selected word is written at the clock edge and dirty is set.
  - Miss with valid & dirty victim: go to WRITEBACK.
  - Any other miss: go to REFILL.
- WRITEBACK:
  - Drive `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o={victim tag, index, 5'b0}`, `mem_data_o`=victim line.
  - On `mem_ack_i`: go to REFILL.
- REFILL:
  - Drive `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o={request tag, index, 5'b0}`.
  - On `mem_ack_i`: write `mem_data_i` to the line, set valid=1, dirty=0, tag=request tag; go to IDLE.
- After a refill, the request is re-evaluated in IDLE. It now hits, so a store miss merges its word then and sets dirty (write-allocate).
- `stall_o` is 1 in WRITEBACK and REFILL regardless of the inputs.
- The requester holds `core_*` inputs stable while `stall_o` is high. The controller samples the request index/tag at the IDLE→miss edge into internal registers and uses the registered values for all memory addresses.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_data_o` are stable from assertion until the edge on which ack is sampled.
- `mem_ack_i` while `mem_req_o` is low is ignored.
- `core_req_i` low in IDLE: no state change, `stall_o=0`. `core_data_o` is don't-care; it is driven with the addressed word.

## Timing
- Hit: zero added latency. Load data is combinational; a store commits at the next edge.
- Clean miss:
  - `stall_o` rises in cycle 0.
  - REFILL starts in cycle 1.
  - If ack is sampled at the end of cycle k, IDLE hits in cycle k+1 and `stall_o` falls then.
- Dirty miss adds the WRITEBACK duration, with a minimum of 1 cycle.
- Each state lasts at least one cycle. Ack in the first cycle of the request is legal.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE; all valid/dirty bits=0; `mem_req_o=0`, `mem_we_o=0`.
  - `mem_addr_o=0`, `mem_data_o=0`.
  - Counters are cleared.
  - Tag and data arrays are not cleared.
  - `stall_o` follows the IDLE equation, so it is 1 if `core_req_i` is high, because every line is invalid.
- An abandoned transaction is not resumed.

## Configuration
- `DCACHE_STATS_EN` defined: adds output ports `hit_cnt_o` [31:0] and `miss_cnt_o` [31:0].
  - hit_cnt increments on each IDLE-state hit edge. The post-refill hit counts as a hit.
  - miss_cnt increments on each IDLE→miss transition edge.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Cold load from 0x0000_0104 after reset, memory acks on the 3rd request cycle with line word1=0xDEADBEEF:
  - `stall_o` is high for 4 cycles (miss cycle + 3 REFILL cycles) and `mem_addr_o`=0x0000_0100 during REFILL.
  - In the following cycle `core_data_o`=0xDEADBEEF and `stall_o`=0.
- Store 0x12345678 to 0x0000_0108 (hit), then load 0x0000_0108 → 0x12345678 with `stall_o=0` on both accesses.
- Then load 0x0000_0300, same index with NUM_LINES=16:
  - WRITEBACK first, with `mem_we_o=1`, `mem_addr_o`=0x0000_0100, and `mem_data_o` word2=0x12345678.
  - REFILL follows with `mem_addr_o`=0x0000_0300.
- Store miss to 0x0000_0010 → REFILL only (line clean/invalid), then the merged word is visible on a subsequent load, and the line is dirty: a later conflicting access triggers WRITEBACK.
- Assert `rst_i`=0 mid-REFILL → `mem_req_o` drops immediately. After release, a load of the same address misses again.
- With `DCACHE_STATS_EN`, the scenario above (cold miss + 3 accesses) → `hit_cnt_o`=3, `miss_cnt_o`=1.
